// File: rtl/bw_io_term_pkg.sv
// Shared types and constants for the CMOS2 pulldown termination calibration slice.
package bw_io_term_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_SAMPLE = 3'd2,
      ST_LOCKED = 3'd3,
      ST_TRACK  = 3'd4
   } term_cal_st_t;

   // A tracking pass gives up after this many filter thresholds' worth of samples.
   localparam int TRACK_MAX_SMP = 4;

   function automatic int unsigned term_midscale(input int unsigned code_w);
      return 32'd1 << (code_w - 32'd1);
   endfunction

endpackage

// File: rtl/bw_io_term_filt.sv
// Comparator synchronizer plus signed up/down vote filter.
// step_up/step_dn are combinational pulses in the sample cycle that reaches
// the threshold; the filter empties itself on that same edge.
module bw_io_term_filt #(
   parameter int FILT_TH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic comp_hi,
   input  logic clear,
   input  logic sample_en,
   output logic step_up,
   output logic step_dn
);
   localparam int FW = $clog2(FILT_TH + 1) + 1;
   localparam logic signed [FW-1:0] F_ONE = FW'(1);
   localparam logic signed [FW-1:0] TH_P  = FW'(FILT_TH);
   localparam logic signed [FW-1:0] TH_N  = FW'(-FILT_TH);

   logic                 sync1_q, sync1_d;
   logic                 sync2_q, sync2_d;
   logic signed [FW-1:0] filt_q, filt_d, filt_nxt;

   // Vote accumulation and threshold detection.
   always_comb begin
      sync1_d  = comp_hi;
      sync2_d  = sync1_q;
      filt_nxt = sync2_q ? (filt_q + F_ONE) : (filt_q - F_ONE);
      step_up  = sample_en && !clear && (filt_nxt == TH_P);
      step_dn  = sample_en && !clear && (filt_nxt == TH_N);
      filt_d   = filt_q;
      if (clear)
         filt_d = '0;
      else if (sample_en)
         filt_d = (step_up || step_dn) ? '0 : filt_nxt;
   end

   // Synchronizer and filter state.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         filt_q  <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         filt_q  <= filt_d;
      end
   end

endmodule

// File: rtl/bw_io_cmos2_term_cal.sv
// Closed-loop pulldown termination calibration: one-shot lock, then periodic tracking.
//
//   state  | meaning
//   IDLE   | out of reset, waiting for cal_start
//   SETTLE | waiting for pads to settle on the applied code
//   SAMPLE | voting comparator samples, stepping code, counting reversals
//   LOCKED | code calibrated; interval timer runs when cal_en=1
//   TRACK  | single filter pass, at most one code step, then back to LOCKED
module bw_io_cmos2_term_cal import bw_io_term_pkg::*; #(
   parameter int CODE_W   = 6,
   parameter int SETTLE   = 8,
   parameter int FILT_TH  = 4,
   parameter int INTERVAL = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cal_start,
   input  logic              cal_en,
   input  logic              comp_hi,
   input  logic              upd_ok,
   output logic [CODE_W-1:0] term_code,
   output logic              code_vld,
   output logic              cal_busy,
   output logic              cal_done,
   output logic              cal_err
);
   localparam logic [CODE_W-1:0] CODE_MID = CODE_W'(term_midscale(CODE_W));
   localparam logic [CODE_W-1:0] CODE_MAX = '1;
   localparam logic [CODE_W-1:0] CODE_ONE = CODE_W'(1);
   localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SET_W-1:0]  SET_LD   = SET_W'(SETTLE - 1);
   localparam int INT_W = $clog2(INTERVAL);
   localparam logic [INT_W-1:0]  INT_TC   = INT_W'(INTERVAL - 1);
   localparam int SMP_N = TRACK_MAX_SMP * FILT_TH;
   localparam int SMP_W = (SMP_N > 1) ? $clog2(SMP_N) : 1;
   localparam logic [SMP_W-1:0]  SMP_TC   = SMP_W'(SMP_N - 1);
   localparam logic [1:0] DIR_NONE = 2'd0;
   localparam logic [1:0] DIR_UP   = 2'd1;
   localparam logic [1:0] DIR_DN   = 2'd2;

   term_cal_st_t      state_q, state_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic [CODE_W-1:0] term_code_q, term_code_d;
   logic [SET_W-1:0]  set_cnt_q, set_cnt_d;
   logic [INT_W-1:0]  int_cnt_q, int_cnt_d;
   logic [SMP_W-1:0]  smp_cnt_q, smp_cnt_d;
   logic [1:0]        dir_q, dir_d;
   logic              rev_q, rev_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic              filt_clr, sample_en, step_up, step_dn;
   logic              restart, stepping, sat;
   logic [1:0]        dir_new;

   bw_io_term_filt #(.FILT_TH(FILT_TH)) u_filt (
      .clk       (clk),
      .rst       (rst),
      .comp_hi   (comp_hi),
      .clear     (filt_clr),
      .sample_en (sample_en),
      .step_up   (step_up),
      .step_dn   (step_dn)
   );

   // Next-state, code stepping, counters and the update-window apply rule.
   always_comb begin
      state_d   = state_q;
      code_d    = code_q;
      set_cnt_d = set_cnt_q;
      int_cnt_d = '0;
      smp_cnt_d = smp_cnt_q;
      dir_d     = dir_q;
      rev_d     = rev_q;
      err_d     = err_q;
      done_d    = 1'b0;
      filt_clr  = 1'b0;
      sample_en = 1'b0;
      restart   = 1'b0;
      stepping  = step_up || step_dn;
      sat       = (step_up && code_q == CODE_MAX) || (step_dn && code_q == '0);
      dir_new   = step_up ? DIR_UP : DIR_DN;
      case (state_q)
         ST_IDLE: begin
            if (cal_start) restart = 1'b1;
         end
         ST_SETTLE: begin
            // Hold the timer until the pads actually carry the working code.
            if (term_code_q != code_q)
               set_cnt_d = SET_LD;
            else if (set_cnt_q == '0)
               state_d = ST_SAMPLE;
            else
               set_cnt_d = set_cnt_q - SET_W'(1);
         end
         ST_SAMPLE: begin
            sample_en = 1'b1;
            if (stepping) begin
               if (sat) begin
                  err_d   = 1'b1;
                  state_d = ST_LOCKED;
                  done_d  = 1'b1;
               end else begin
                  code_d    = step_up ? (code_q + CODE_ONE) : (code_q - CODE_ONE);
                  dir_d     = dir_new;
                  state_d   = ST_SETTLE;
                  set_cnt_d = SET_LD;
                  if (dir_q != DIR_NONE && dir_q != dir_new) begin
                     if (rev_q) begin
                        state_d = ST_LOCKED;
                        done_d  = 1'b1;
                     end else begin
                        rev_d = 1'b1;
                     end
                  end
               end
            end
         end
         ST_LOCKED: begin
            if (cal_start) begin
               restart = 1'b1;
            end else if (cal_en) begin
               if (int_cnt_q == INT_TC) begin
                  state_d   = ST_TRACK;
                  filt_clr  = 1'b1;
                  smp_cnt_d = '0;
               end else begin
                  int_cnt_d = int_cnt_q + INT_W'(1);
               end
            end
         end
         ST_TRACK: begin
            if (cal_start) begin
               restart = 1'b1;
            end else begin
               sample_en = 1'b1;
               if (stepping) begin
                  if (sat)
                     err_d = 1'b1;
                  else
                     code_d = step_up ? (code_q + CODE_ONE) : (code_q - CODE_ONE);
                  state_d = ST_LOCKED;
                  done_d  = 1'b1;
               end else if (smp_cnt_q == SMP_TC) begin
                  state_d = ST_LOCKED;
                  done_d  = 1'b1;
               end else begin
                  smp_cnt_d = smp_cnt_q + SMP_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A restart overrides anything the current state decided, including a track commit.
      if (restart) begin
         state_d   = ST_SETTLE;
         code_d    = CODE_MID;
         set_cnt_d = SET_LD;
         dir_d     = DIR_NONE;
         rev_d     = 1'b0;
         err_d     = 1'b0;
         done_d    = 1'b0;
         filt_clr  = 1'b1;
      end
      term_code_d = upd_ok ? code_d : term_code_q;
   end

   // Controller registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         code_q      <= CODE_MID;
         term_code_q <= CODE_MID;
         set_cnt_q   <= SET_LD;
         int_cnt_q   <= '0;
         smp_cnt_q   <= '0;
         dir_q       <= DIR_NONE;
         rev_q       <= 1'b0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         term_code_q <= term_code_d;
         set_cnt_q   <= set_cnt_d;
         int_cnt_q   <= int_cnt_d;
         smp_cnt_q   <= smp_cnt_d;
         dir_q       <= dir_d;
         rev_q       <= rev_d;
         err_q       <= err_d;
         done_q      <= done_d;
      end
   end

   assign term_code = term_code_q;
   assign code_vld  = (state_q == ST_LOCKED) || (state_q == ST_TRACK);
   assign cal_busy  = (state_q != ST_IDLE) && (state_q != ST_LOCKED);
   assign cal_done  = done_q;
   assign cal_err   = err_q;

endmodule

// File: tb/tb_bw_io_cmos2_term_cal.sv
// Directed bench for the termination calibration controller. Expected lock
// results are queued when a calibration is launched and checked on cal_done.
module tb_bw_io_cmos2_term_cal;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cal_start = 1'b0;
   logic       cal_en = 1'b0;
   logic       upd_ok = 1'b1;
   logic       comp_hi;
   logic [5:0] term_code;
   logic       code_vld, cal_busy, cal_done, cal_err;

   logic       comp_thr_mode = 1'b0;
   logic       comp_force = 1'b0;
   logic [5:0] comp_thr = 6'd40;

   int n_chk = 0;
   int n_err = 0;

   typedef struct packed {
      logic [5:0] code;
      logic       err;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   // Pad model: above VREF while the code is below the threshold, or a forced level.
   assign comp_hi = comp_thr_mode ? (term_code < comp_thr) : comp_force;

   bw_io_cmos2_term_cal dut (
      .clk       (clk),
      .rst       (rst),
      .cal_start (cal_start),
      .cal_en    (cal_en),
      .comp_hi   (comp_hi),
      .upd_ok    (upd_ok),
      .term_code (term_code),
      .code_vld  (code_vld),
      .cal_busy  (cal_busy),
      .cal_done  (cal_done),
      .cal_err   (cal_err)
   );

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      cal_start = 1'b1;
      @(posedge clk); #1;
      cal_start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int max_cyc);
      int k;
      k = 0;
      do begin
         @(posedge clk); #1;
         k++;
      end while (!cal_done && k < max_cyc);
      if (!cal_done) begin
         n_chk++;
         n_err++;
         $display("FAIL %s: timeout after %0d cycles, cal_done=0 expected 1", name, k);
      end
   endtask

   // Monitor: every cal_done pulse consumes one expected lock result.
   initial begin
      logic prev_done;
      exp_t e;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (cal_done && !rst) begin
            if (sb_q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL sb_unexpected_done: got cal_done=1 expected 0 (term_code=%0d)", term_code);
            end else begin
               e = sb_q.pop_front();
               check("sb_term_code", int'(term_code), int'(e.code));
               check("sb_cal_err", int'(cal_err), int'(e.err));
               check("sb_code_vld", int'(code_vld), 1);
               check("sb_done_single", int'(prev_done), 0);
            end
         end
         prev_done = cal_done;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cnt;
      logic vld_drop;

      // Reset values
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_term_code", int'(term_code), 32);
      check("rst_code_vld", int'(code_vld), 0);
      check("rst_cal_busy", int'(cal_busy), 0);
      check("rst_cal_done", int'(cal_done), 0);
      check("rst_cal_err", int'(cal_err), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_busy", int'(cal_busy), 0);

      // 1: threshold at 40, climb and lock after two reversals
      comp_thr_mode = 1'b1;
      comp_thr      = 6'd40;
      sb_q.push_back('{code: 6'd40, err: 1'b0});
      pulse_start();
      check("t1_busy", int'(cal_busy), 1);
      check("t1_vld_low", int'(code_vld), 0);
      wait_done("t1_lock", 1000);
      @(posedge clk); #1;
      check("t1_done_pulse_end", int'(cal_done), 0);
      check("t1_vld_hold", int'(code_vld), 1);

      // 2: comparator stuck high saturates at max
      comp_thr_mode = 1'b0;
      comp_force    = 1'b1;
      sb_q.push_back('{code: 6'd63, err: 1'b1});
      pulse_start();
      wait_done("t2_lock", 1000);

      // 3: update window closed during calibration
      comp_force = 1'b0;
      upd_ok     = 1'b0;
      sb_q.push_back('{code: 6'd0, err: 1'b1});
      pulse_start();
      repeat (50) @(posedge clk);
      #1;
      check("t3_frozen_code", int'(term_code), 63);
      check("t3_busy", int'(cal_busy), 1);
      check("t3_err_cleared", int'(cal_err), 0);
      upd_ok = 1'b1;
      @(posedge clk); #1;
      check("t3_apply_same_cycle", int'(term_code), 32);
      cnt = 0;
      do begin
         @(posedge clk); #1;
         cnt++;
      end while (term_code == 6'd32 && cnt < 100);
      check("t3_settle_then_step_cycles", cnt, 12);
      check("t3_first_step_code", int'(term_code), 31);
      wait_done("t3_lock", 1000);

      // 4: lock at 40, then track upward by exactly one
      comp_thr_mode = 1'b1;
      comp_thr      = 6'd40;
      sb_q.push_back('{code: 6'd40, err: 1'b0});
      pulse_start();
      wait_done("t4_lock", 1000);
      comp_thr_mode = 1'b0;
      comp_force    = 1'b1;
      cal_en        = 1'b1;
      sb_q.push_back('{code: 6'd41, err: 1'b0});
      cnt      = 0;
      vld_drop = 1'b0;
      do begin
         @(posedge clk); #1;
         cnt++;
         if (!code_vld) vld_drop = 1'b1;
      end while (term_code == 6'd40 && cnt < 1100);
      check("t4_track_latency", cnt, 1028);
      check("t4_track_code", int'(term_code), 41);
      check("t4_vld_never_dropped", int'(vld_drop), 0);

      // 6: cal_start lands on the TRACK commit cycle
      cnt = 0;
      do begin
         @(posedge clk); #1;
         cnt++;
      end while (!(cal_busy && code_vld) && cnt < 1100);
      check("t6_track_entry_cycles", cnt, 1024);
      repeat (3) @(posedge clk);
      #1;
      cal_start = 1'b1;
      @(posedge clk); #1;
      cal_start = 1'b0;
      cal_en    = 1'b0;
      check("t6_restart_code", int'(term_code), 32);
      check("t6_vld_low", int'(code_vld), 0);
      check("t6_busy", int'(cal_busy), 1);
      check("t6_no_done", int'(cal_done), 0);

      // 5: reset while sampling, two steps into the restarted run
      repeat (34) @(posedge clk);
      #1;
      check("t5_pre_reset_code", int'(term_code), 34);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("t5_term_code", int'(term_code), 32);
      check("t5_code_vld", int'(code_vld), 0);
      check("t5_cal_busy", int'(cal_busy), 0);
      check("t5_cal_done", int'(cal_done), 0);
      check("t5_cal_err", int'(cal_err), 0);
      repeat (20) @(posedge clk);
      #1;
      check("t5_stays_idle", int'(cal_busy), 0);
      check("t5_code_held", int'(term_code), 32);

      check("sb_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
